// File: rtl/ioctl_rom_loader.sv
// HPS ioctl download front-end: routes ROM bytes to two SDRAM ports or the PROM,
// captures core_mod / DIP bytes, and holds the core in reset until the ROM is loaded.
module ioctl_rom_loader #(
  parameter logic [24:0] P2_BASE      = 25'h30000,
  parameter logic [24:0] PROM_BASE    = 25'hA0000,
  parameter logic [11:0] PROM_SIZE    = 12'h920,
  parameter logic [15:0] RESET_CYCLES = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        soft_reset,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port_d,
  output logic        prom_wr,
  output logic [11:0] prom_addr,
  output logic [7:0]  prom_data,
  output logic [7:0]  core_mod,
  output logic [63:0] dip_sw,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        busy,
  output logic        overrun
);

  localparam logic [24:0] PROM_END = PROM_BASE + {13'd0, PROM_SIZE};

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  logic [1:0]  state;
  logic        wr_prev, dl_prev, dl_done;
  logic        wr_ev, rom_ev, sdram_ev, prom_ev;
  logic        skid_full, mirror, pend_mirror;
  logic [24:0] skid_addr, pend_addr;
  logic [7:0]  skid_byte, pend_byte;
  logic [23:0] p2_off;
  logic [11:0] prom_off;
  logic [15:0] cnt, cnt_next;

  assign wr_ev       = ioctl_download & ioctl_wr & ~wr_prev;
  assign rom_ev      = wr_ev && (ioctl_index == 8'd0);
  assign sdram_ev    = rom_ev && (ioctl_addr < PROM_BASE);
  assign prom_ev     = rom_ev && (ioctl_addr >= PROM_BASE) && (ioctl_addr < PROM_END);
  assign pend_mirror = (pend_addr >= P2_BASE);
  assign p2_off      = pend_addr[23:0] - P2_BASE[23:0];
  assign prom_off    = ioctl_addr[11:0] - PROM_BASE[11:0];
  assign busy        = (state != ST_IDLE) | skid_full;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      skid_full <= 1'b0;
      skid_addr <= '0;
      skid_byte <= '0;
      pend_addr <= '0;
      pend_byte <= '0;
      mirror    <= 1'b0;
      port1_req <= 1'b0;
      port2_req <= 1'b0;
      port1_a   <= '0;
      port2_a   <= '0;
      port1_ds  <= '0;
      port2_ds  <= '0;
      port_d    <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (skid_full) begin
            pend_addr <= skid_addr;
            pend_byte <= skid_byte;
            state     <= ST_ISSUE;
            // a new event in the same cycle takes the slot just freed
            skid_full <= sdram_ev;
            if (sdram_ev) begin
              skid_addr <= ioctl_addr;
              skid_byte <= ioctl_dout;
            end
          end else if (sdram_ev) begin
            pend_addr <= ioctl_addr;
            pend_byte <= ioctl_dout;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          port1_a   <= pend_addr[23:1];
          port1_ds  <= {pend_addr[0], ~pend_addr[0]};
          port_d    <= {pend_byte, pend_byte};
          port1_req <= ~port1_req;
          mirror    <= pend_mirror;
          if (pend_mirror) begin
            port2_a   <= p2_off[23:1];
            port2_ds  <= {p2_off[0], ~p2_off[0]};
            port2_req <= ~port2_req;
          end
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if ((port1_ack == port1_req) && (!mirror || (port2_ack == port2_req)))
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if ((state != ST_IDLE) && sdram_ev) begin
        if (!skid_full) begin
          skid_full <= 1'b1;
          skid_addr <= ioctl_addr;
          skid_byte <= ioctl_dout;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_next = cnt;
    if (soft_reset || !rom_loaded)
      cnt_next = RESET_CYCLES;
    else if (cnt != 16'd0)
      cnt_next = cnt - 16'd1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev    <= 1'b0;
      dl_prev    <= 1'b0;
      dl_done    <= 1'b0;
      prom_wr    <= 1'b0;
      prom_addr  <= '0;
      prom_data  <= '0;
      core_mod   <= '0;
      dip_sw     <= '0;
      rom_loaded <= 1'b0;
      cnt        <= RESET_CYCLES;
      core_reset <= 1'b1;
    end else begin
      wr_prev <= ioctl_wr;
      dl_prev <= ioctl_download;
      prom_wr <= prom_ev;
      if (prom_ev) begin
        prom_addr <= prom_off;
        prom_data <= ioctl_dout;
      end
      if (wr_ev && (ioctl_index == 8'd1))
        core_mod <= ioctl_dout;
      if (wr_ev && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0))
        dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      // the loaded flag waits for the last SDRAM write to drain
      if (dl_done && !busy) begin
        rom_loaded <= 1'b1;
        dl_done    <= 1'b0;
      end
      if (dl_prev && !ioctl_download && (ioctl_index == 8'd0))
        dl_done <= 1'b1;
      cnt        <= cnt_next;
      core_reset <= (cnt_next != 16'd0);
    end
  end

endmodule

// File: doc/ioctl_rom_loader.md
IOCTL_ROM_LOADER -- requirements
Module: ioctl_rom_loader

Interface
REQ-001 SHALL have parameter P2_BASE, default 25'h30000, first byte address also mirrored to sprite port 2.
REQ-002 SHALL have parameter PROM_BASE, default 25'hA0000, first PROM byte address.
REQ-003 SHALL have parameter PROM_SIZE, default 12'h920, PROM region length in bytes.
REQ-004 SHALL have parameter RESET_CYCLES, default 16'hFFFF, core reset stretch length.
REQ-005 clk_sys  in  1  system clock; all logic on rising edge; one clock only.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 ioctl_download  in  1  HPS download active.
REQ-008 ioctl_index  in  8  file index: 0 ROM, 1 core_mod, 254 DIP.
REQ-009 ioctl_wr  in  1  byte strobe; level, edge-detected internally.
REQ-010 ioctl_addr  in  25  byte address.
REQ-011 ioctl_dout  in  8  byte data.
REQ-012 soft_reset  in  1  OSD/button reset request.
REQ-013 port1_req / port2_req  out  1 each  toggle request to SDRAM port.
REQ-014 port1_ack / port2_ack  in  1 each  toggle acknowledge; equal to req = idle.
REQ-015 port1_a / port2_a  out  23  word address; port1_ds / port2_ds  out  2  byte strobes {a[0],~a[0]}; port_d  out  16  {byte,byte}.
REQ-016 prom_wr  out  1  one-cycle PROM write pulse; prom_addr  out  12; prom_data  out  8.
REQ-017 core_mod  out  8; dip_sw  out  64 (byte n = dip_sw[8n+7:8n]).
REQ-018 rom_loaded  out  1; core_reset  out  1 active-high; busy  out  1; overrun  out  1 sticky.

Function
REQ-019 Write event = ioctl_wr rising edge (registered previous value) while ioctl_download=1.
REQ-020 Index 0 decode: addr<P2_BASE -> port1 only; P2_BASE<=addr<PROM_BASE -> port1 and port2, port2 byte addr = addr-P2_BASE; PROM_BASE<=addr<PROM_BASE+PROM_SIZE -> prom_wr only; above -> ignored, no side effect.
REQ-021 PROM write: prom_wr high exactly the cycle after the event, prom_addr=addr-PROM_BASE, prom_data=byte; no SDRAM traffic.
REQ-022 SDRAM FSM states IDLE, ISSUE, WAIT_ACK.
REQ-023 IDLE: event or skid entry for SDRAM -> ISSUE (next cycle); skid has priority over new event, new event then enters skid.
REQ-024 ISSUE: latch port address/data/ds, toggle port1_req, toggle port2_req if mirrored; -> WAIT_ACK.
REQ-025 WAIT_ACK: stay until port1_ack==port1_req and (not mirrored or port2_ack==port2_req); then -> IDLE.
REQ-026 Port address/data outputs SHALL hold stable from ISSUE until return to IDLE.
REQ-027 One-entry skid buffer holds {addr,byte} of an SDRAM event arriving while FSM not IDLE; event arriving with skid full SHALL be dropped and set overrun until reset_n.
REQ-028 busy = FSM not IDLE or skid full.
REQ-029 Index 1 event: core_mod <= byte (any address; last write wins).
REQ-030 Index 254 event with addr[24:3]==0: dip_sw byte addr[2:0] <= byte; other addresses ignored.
REQ-031 rom_loaded set once when, after a falling edge of ioctl_download with ioctl_index==0 observed, busy==0; never cleared except reset_n; index 1/254 downloads never set it.
REQ-032 Reset counter loads RESET_CYCLES while soft_reset or ~rom_loaded, else decrements to 0 and holds; core_reset = (counter!=0), registered.
REQ-033 New download start (index 0 rising ioctl_download) after rom_loaded SHALL NOT clear rom_loaded.

Reset
REQ-034 reset_n low: FSM IDLE, skid empty, port*_req=0, prom_wr=0, core_mod=0, dip_sw=0, rom_loaded=0, overrun=0, counter=RESET_CYCLES, core_reset=1, previous-strobe regs 0.
REQ-035 reset_n low mid-transfer aborts request immediately; SDRAM handshake resynchronises only by reset of both sides.

Verification
REQ-036 Index 0, addr 0x00010, byte 0xA5, ack after 3 cycles -> port1_req toggles once, port1_a=0x8, ds=2'b01, d=16'hA5A5, port2_req unchanged, busy drops after ack.
REQ-037 Index 0, addr 0x30003, byte 0x3C -> both reqs toggle, port1_a=0x18001, port2_a=0x1, ds=2'b10 on both; IDLE only after both acks.
REQ-038 Index 0, addr 0xA0305, byte 0x77 -> prom_wr one cycle, prom_addr=0x305, data 0x77; addr 0xA0920 -> nothing.
REQ-039 Ack withheld, three events in a row -> first issued, second in skid, third dropped, overrun=1; after ack second issued next-but-one cycle.
REQ-040 Index 254 bytes 0x11..0x18 at addr 0..7, addr 8 byte 0xFF -> dip_sw=64'h1817161514131211.
REQ-041 Index 0 download end with idle FSM, RESET_CYCLES=16 -> rom_loaded=1, core_reset falls 16 cycles later; soft_reset pulse -> core_reset high, falls 16 cycles after release.
